// File: rtl/st7066u_lcd_sequencer.sv
// st7066u_lcd_sequencer
// Drives the 8-bit ST7066U character-LCD bus. After reset it waits out the
// controller power-up time, sends the four-byte init sequence, then accepts
// single command/data bytes through a ready/request handshake. Every byte
// gets RS/DB setup, an E strobe, a hold cycle and the execution delay.
module st7066u_lcd_sequencer #(
    parameter int POWERUP_CYCLES   = 480000,
    parameter int E_PULSE_CYCLES   = 7,
    parameter int EXEC_CYCLES      = 480,
    parameter int LONG_EXEC_CYCLES = 19200
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_init_done,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_e,
    output logic [7:0] o_lcd_db
);

    // One shared counter covers every timed state, so it is sized for the longest wait.
    localparam int MAX_AB  = (POWERUP_CYCLES > E_PULSE_CYCLES) ? POWERUP_CYCLES : E_PULSE_CYCLES;
    localparam int MAX_CD  = (EXEC_CYCLES > LONG_EXEC_CYCLES) ? EXEC_CYCLES : LONG_EXEC_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(E_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        PWR_WAIT,
        SETUP,
        STROBE,
        HOLD,
        EXEC_WAIT,
        IDLE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_idx;
    logic             running_init;
    logic             init_done;
    logic             lcd_rs;
    logic [7:0]       lcd_db;

    logic             load;
    logic             load_rs;
    logic [7:0]       load_db;
    logic             idx_step;
    logic             finish_init;
    logic             long_write;
    logic [CNT_W-1:0] exec_last;

    // Init bytes: 8-bit/2-line/5x8, display on, clear, entry increment.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear and home commands need the long execution delay.
    assign long_write = !lcd_rs && ((lcd_db == 8'h01) || (lcd_db == 8'h02) || (lcd_db == 8'h03));
    assign exec_last  = long_write ? LONG_LAST : EXEC_LAST;

    assign o_ready     = (state == IDLE);
    assign o_lcd_e     = (state == STROBE);
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_rs    = lcd_rs;
    assign o_lcd_db    = lcd_db;
    assign o_init_done = init_done;

    // Next-state logic and byte-load selection for init and host writes.
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        load_rs     = 1'b0;
        load_db     = 8'h00;
        idx_step    = 1'b0;
        finish_init = 1'b0;
        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_next = SETUP;
                    load       = 1'b1;
                    load_db    = init_byte(2'd0);
                end
            end
            SETUP: state_next = STROBE;
            STROBE: begin
                if (cnt == E_LAST) begin
                    state_next = HOLD;
                end
            end
            HOLD: state_next = EXEC_WAIT;
            EXEC_WAIT: begin
                if (cnt == exec_last) begin
                    if (running_init && (init_idx != 2'd3)) begin
                        state_next = SETUP;
                        load       = 1'b1;
                        load_db    = init_byte(init_idx + 2'd1);
                        idx_step   = 1'b1;
                    end else begin
                        state_next  = IDLE;
                        finish_init = running_init;
                    end
                end
            end
            IDLE: begin
                if (i_req) begin
                    state_next = SETUP;
                    load       = 1'b1;
                    load_rs    = i_rs;
                    load_db    = i_data;
                end
            end
            default: state_next = PWR_WAIT;
        endcase
    end

    // State, shared counter, init tracking and the latched RS/DB bus.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= PWR_WAIT;
            cnt          <= '0;
            init_idx     <= 2'd0;
            running_init <= 1'b1;
            init_done    <= 1'b0;
            lcd_rs       <= 1'b0;
            lcd_db       <= 8'h00;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CNT_W'(1);
            if (load) begin
                lcd_rs <= load_rs;
                lcd_db <= load_db;
            end
            if (idx_step) begin
                init_idx <= init_idx + 2'd1;
            end
            if (finish_init) begin
                running_init <= 1'b0;
                init_done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_st7066u_lcd_sequencer.sv
// Self-checking bench for st7066u_lcd_sequencer using shortened timing.
// A negedge monitor records every E pulse and checks bus invariants; each
// test compares pulse timing and content against cycle arithmetic.
module tb_st7066u_lcd_sequencer;

    localparam int PWR = 20;
    localparam int EP  = 7;
    localparam int EX  = 10;
    localparam int LEX = 30;

    logic       i_clk;
    logic       i_reset;
    logic       i_req;
    logic       i_rs;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_init_done;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic       o_lcd_e;
    logic [7:0] o_lcd_db;

    st7066u_lcd_sequencer #(
        .POWERUP_CYCLES(PWR),
        .E_PULSE_CYCLES(EP),
        .EXEC_CYCLES(EX),
        .LONG_EXEC_CYCLES(LEX)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_req(i_req),
        .i_rs(i_rs),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_init_done(o_init_done),
        .o_lcd_rs(o_lcd_rs),
        .o_lcd_rw(o_lcd_rw),
        .o_lcd_e(o_lcd_e),
        .o_lcd_db(o_lcd_db)
    );

    typedef struct {
        int         rise;
        int         width;
        logic       rs;
        logic [7:0] db;
    } pulse_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rst_edge = 0;
    logic       rst_q = 1'b0;
    bit         mon_en = 1'b0;
    pulse_t     pulses[$];
    logic [7:0] init_db[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    logic       prev_e = 1'b0;
    logic       prev_rs;
    logic [7:0] prev_db;
    bit         in_pulse = 1'b0;
    pulse_t     cur;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Edge counter and a record of whether reset was sampled at the last edge.
    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_reset;
    end

    // Pulse recorder plus bus invariants checked every cycle.
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_lcd_e && !prev_e) begin
                in_pulse = 1'b1;
                cur.rise = cyc;
                cur.rs   = o_lcd_rs;
                cur.db   = o_lcd_db;
            end
            if (!o_lcd_e && prev_e && !rst_q && in_pulse) begin
                cur.width = cyc - cur.rise;
                pulses.push_back(cur);
                in_pulse = 1'b0;
            end
            if (rst_q) in_pulse = 1'b0;
            if (!rst_q && (o_lcd_e || prev_e)) begin
                checks++;
                if (o_lcd_rs !== prev_rs || o_lcd_db !== prev_db) begin
                    errors++;
                    $display("[TB] FAIL bus_stable @%0d: got rs=%0b db=%h expected rs=%0b db=%h",
                             cyc, o_lcd_rs, o_lcd_db, prev_rs, prev_db);
                end
            end
            checks++;
            if (o_lcd_rw !== 1'b0) begin
                errors++;
                $display("[TB] FAIL lcd_rw @%0d: got %0b expected 0", cyc, o_lcd_rw);
            end
            checks++;
            if (o_ready === 1'b1 && o_lcd_e === 1'b1) begin
                errors++;
                $display("[TB] FAIL ready_and_e @%0d: got both 1 expected not both", cyc);
            end
        end
        prev_e  = o_lcd_e;
        prev_rs = o_lcd_rs;
        prev_db = o_lcd_db;
    end

    // Reference rule: clear/home commands (RS=0, DB 1..3) take the long wait.
    function automatic int wait_of(input logic rs, input logic [7:0] db);
        return (!rs && db >= 8'h01 && db <= 8'h03) ? LEX : EX;
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        rst_edge = cyc;
        i_reset = 1'b0;
        pulses.delete();
        mon_en = 1'b1;
    endtask

    // Waits for ready, issues one write, and measures acceptance and completion.
    task automatic issue_write(input logic rs, input logic [7:0] db, output int acc,
                               output logic s_rs, output logic [7:0] s_db, output logic s_e,
                               output logic s_rdy, output int rdy_cyc);
        pulses.delete();
        rdy_cyc = -1;
        for (int k = 0; k < 300; k++) begin
            if (o_ready === 1'b1) break;
            @(negedge i_clk);
        end
        i_req  = 1'b1;
        i_rs   = rs;
        i_data = db;
        @(negedge i_clk);
        acc    = cyc;
        i_req  = 1'b0;
        i_rs   = 1'($urandom);
        i_data = 8'($urandom);
        s_rs   = o_lcd_rs;
        s_db   = o_lcd_db;
        s_e    = o_lcd_e;
        s_rdy  = o_ready;
        for (int k = 0; k < 300; k++) begin
            @(negedge i_clk);
            if (o_ready === 1'b1) begin
                rdy_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (o_ready !== 1'b0)     begin errors++; $display("[TB] FAIL rst_ready: got %0b expected 0", o_ready); end
        if (o_init_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %0b expected 0", o_init_done); end
        if (o_lcd_e !== 1'b0)     begin errors++; $display("[TB] FAIL rst_e: got %0b expected 0", o_lcd_e); end
        if (o_lcd_rs !== 1'b0)    begin errors++; $display("[TB] FAIL rst_rs: got %0b expected 0", o_lcd_rs); end
        if (o_lcd_rw !== 1'b0)    begin errors++; $display("[TB] FAIL rst_rw: got %0b expected 0", o_lcd_rw); end
        if (o_lcd_db !== 8'h00)   begin errors++; $display("[TB] FAIL rst_db: got %h expected 00", o_lcd_db); end
    endtask

    // Checks the four init pulses that follow the reset at rst_edge.
    task automatic test_powerup();
        int     s;
        int     ready_cyc;
        logic   rdy;
        logic   dn;
        int     gap;
        int     gaps[4] = '{10, 10, 30, 10};
        pulse_t p;
        ready_cyc = -1;
        rdy = 1'b0;
        dn = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge i_clk);
            if (o_ready === 1'b1 || o_init_done === 1'b1) begin
                ready_cyc = cyc;
                rdy = o_ready;
                dn = o_init_done;
                break;
            end
        end
        s = rst_edge + PWR;
        checks++;
        if (pulses.size() != 4) begin errors++; $display("[TB] FAIL init_count: got %0d expected 4", pulses.size()); end
        for (int i = 0; i < 4 && i < pulses.size(); i++) begin
            p = pulses[i];
            checks += 5;
            if (p.rise !== s + 1) begin errors++; $display("[TB] FAIL init_rise[%0d]: got %0d expected %0d", i, p.rise, s + 1); end
            if (p.width !== EP)   begin errors++; $display("[TB] FAIL init_width[%0d]: got %0d expected %0d", i, p.width, EP); end
            if (p.rs !== 1'b0)    begin errors++; $display("[TB] FAIL init_rs[%0d]: got %0b expected 0", i, p.rs); end
            if (p.db !== init_db[i]) begin errors++; $display("[TB] FAIL init_db[%0d]: got %h expected %h", i, p.db, init_db[i]); end
            if (i < 3) gap = (i + 1 < pulses.size()) ? pulses[i + 1].rise - (p.rise + p.width) - 2 : -1;
            else       gap = ready_cyc - (p.rise + p.width) - 1;
            if (gap !== gaps[i]) begin errors++; $display("[TB] FAIL init_gap[%0d]: got %0d expected %0d", i, gap, gaps[i]); end
            s = s + 2 + EP + wait_of(1'b0, init_db[i]);
        end
        checks += 2;
        if (ready_cyc !== s) begin errors++; $display("[TB] FAIL init_ready_cyc: got %0d expected %0d", ready_cyc, s); end
        if (!(rdy === 1'b1 && dn === 1'b1)) begin
            errors++;
            $display("[TB] FAIL init_ready_done_together: got ready=%0b done=%0b expected 1 1", rdy, dn);
        end
    endtask

    task automatic test_data_write();
        int acc, rdy_cyc;
        logic s_rs, s_e, s_rdy;
        logic [7:0] s_db;
        pulse_t p;
        issue_write(1'b1, 8'h41, acc, s_rs, s_db, s_e, s_rdy, rdy_cyc);
        p.rise = -1; p.width = -1; p.rs = 1'bx; p.db = 8'hxx;
        if (pulses.size() > 0) p = pulses[0];
        checks += 9;
        if (s_rs !== 1'b1)    begin errors++; $display("[TB] FAIL dw_setup_rs: got %0b expected 1", s_rs); end
        if (s_db !== 8'h41)   begin errors++; $display("[TB] FAIL dw_setup_db: got %h expected 41", s_db); end
        if (s_e !== 1'b0)     begin errors++; $display("[TB] FAIL dw_setup_e: got %0b expected 0", s_e); end
        if (s_rdy !== 1'b0)   begin errors++; $display("[TB] FAIL dw_setup_ready: got %0b expected 0", s_rdy); end
        if (p.rise !== acc + 1) begin errors++; $display("[TB] FAIL dw_rise: got %0d expected %0d", p.rise, acc + 1); end
        if (p.width !== 7)    begin errors++; $display("[TB] FAIL dw_width: got %0d expected 7", p.width); end
        if (p.rs !== 1'b1)    begin errors++; $display("[TB] FAIL dw_rs: got %0b expected 1", p.rs); end
        if (p.db !== 8'h41)   begin errors++; $display("[TB] FAIL dw_db: got %h expected 41", p.db); end
        if (rdy_cyc - acc !== 19) begin errors++; $display("[TB] FAIL dw_busy: got %0d expected 19", rdy_cyc - acc); end
    endtask

    task automatic test_long_command();
        logic       t_rs[7]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] t_db[7]   = '{8'h01, 8'h80, 8'h02, 8'h03, 8'h00, 8'h04, 8'h01};
        int         t_wait[7] = '{30, 10, 30, 30, 10, 10, 10};
        int acc, rdy_cyc, w;
        logic s_rs, s_e, s_rdy;
        logic [7:0] s_db;
        pulse_t p;
        for (int i = 0; i < 7; i++) begin
            issue_write(t_rs[i], t_db[i], acc, s_rs, s_db, s_e, s_rdy, rdy_cyc);
            p.rise = -1; p.width = -1; p.rs = 1'bx; p.db = 8'hxx;
            if (pulses.size() > 0) p = pulses[0];
            w = rdy_cyc - (p.rise + p.width) - 1;
            checks += 2;
            if (p.db !== t_db[i]) begin errors++; $display("[TB] FAIL lc_db[%0d]: got %h expected %h", i, p.db, t_db[i]); end
            if (w !== t_wait[i])  begin errors++; $display("[TB] FAIL lc_wait[%0d]: got %0d expected %0d", i, w, t_wait[i]); end
        end
    endtask

    task automatic test_random_writes();
        int acc, rdy_cyc, exp_rdy;
        logic rs;
        logic [7:0] db;
        logic s_rs, s_e, s_rdy;
        logic [7:0] s_db;
        pulse_t p;
        for (int i = 0; i < 12; i++) begin
            rs = 1'($urandom_range(0, 1));
            db = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            issue_write(rs, db, acc, s_rs, s_db, s_e, s_rdy, rdy_cyc);
            p.rise = -1; p.width = -1; p.rs = 1'bx; p.db = 8'hxx;
            if (pulses.size() > 0) p = pulses[0];
            exp_rdy = acc + 2 + EP + wait_of(rs, db);
            checks += 6;
            if (s_rs !== rs || s_db !== db) begin errors++; $display("[TB] FAIL rw_setup[%0d]: got %0b/%h expected %0b/%h", i, s_rs, s_db, rs, db); end
            if (p.rise !== acc + 1) begin errors++; $display("[TB] FAIL rw_rise[%0d]: got %0d expected %0d", i, p.rise, acc + 1); end
            if (p.width !== EP)     begin errors++; $display("[TB] FAIL rw_width[%0d]: got %0d expected %0d", i, p.width, EP); end
            if (p.rs !== rs)        begin errors++; $display("[TB] FAIL rw_rs[%0d]: got %0b expected %0b", i, p.rs, rs); end
            if (p.db !== db)        begin errors++; $display("[TB] FAIL rw_db[%0d]: got %h expected %h", i, p.db, db); end
            if (rdy_cyc !== exp_rdy) begin errors++; $display("[TB] FAIL rw_ready[%0d]: got %0d expected %0d", i, rdy_cyc, exp_rdy); end
        end
    endtask

    task automatic test_handshake();
        logic       h_rs[5];
        logic [7:0] h_db[5];
        int k = 0;
        int rdy_cnt = 0;
        bit prev_rdy = 1'b0;
        bit early = 1'b0;
        bit dup = 1'b0;
        for (int j = 0; j < 5; j++) begin
            h_rs[j] = 1'($urandom_range(0, 1));
            h_db[j] = 8'($urandom);
        end
        do_reset();
        i_req  = 1'b1;
        i_rs   = h_rs[0];
        i_data = h_db[0];
        for (int c = 0; c < 3000 && k < 5; c++) begin
            @(negedge i_clk);
            if (prev_rdy) begin
                k++;
                if (k < 5) begin
                    i_rs   = h_rs[k];
                    i_data = h_db[k];
                end
            end
            if (o_ready === 1'b1) begin
                rdy_cnt++;
                if (o_init_done !== 1'b1) early = 1'b1;
                if (prev_rdy) dup = 1'b1;
            end
            prev_rdy = (o_ready === 1'b1);
        end
        i_req = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge i_clk);
            if (o_ready === 1'b1) break;
        end
        checks += 5;
        if (k !== 5)       begin errors++; $display("[TB] FAIL hs_accepts: got %0d expected 5", k); end
        if (rdy_cnt !== 5) begin errors++; $display("[TB] FAIL hs_ready_pulses: got %0d expected 5", rdy_cnt); end
        if (early !== 1'b0) begin errors++; $display("[TB] FAIL hs_early_accept: got 1 expected 0"); end
        if (dup !== 1'b0)  begin errors++; $display("[TB] FAIL hs_ready_width: got >1 cycle expected 1"); end
        if (pulses.size() !== 9) begin errors++; $display("[TB] FAIL hs_pulse_count: got %0d expected 9", pulses.size()); end
        for (int j = 0; j < 9 && j < pulses.size(); j++) begin
            checks++;
            if (j < 4) begin
                if (pulses[j].db !== init_db[j] || pulses[j].rs !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL hs_byte[%0d]: got %0b/%h expected 0/%h", j, pulses[j].rs, pulses[j].db, init_db[j]);
                end
            end else if (pulses[j].db !== h_db[j - 4] || pulses[j].rs !== h_rs[j - 4]) begin
                errors++;
                $display("[TB] FAIL hs_byte[%0d]: got %0b/%h expected %0b/%h", j, pulses[j].rs, pulses[j].db, h_rs[j - 4], h_db[j - 4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge i_clk);
            if (o_lcd_e === 1'b1 && o_lcd_db === 8'h01) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL mid_find_third: got none expected E high on 01"); end
        i_reset = 1'b1;
        @(negedge i_clk);
        rst_edge = cyc;
        i_reset = 1'b0;
        pulses.delete();
        checks += 5;
        if (o_lcd_e !== 1'b0)     begin errors++; $display("[TB] FAIL mid_e: got %0b expected 0", o_lcd_e); end
        if (o_lcd_rs !== 1'b0)    begin errors++; $display("[TB] FAIL mid_rs: got %0b expected 0", o_lcd_rs); end
        if (o_lcd_db !== 8'h00)   begin errors++; $display("[TB] FAIL mid_db: got %h expected 00", o_lcd_db); end
        if (o_ready !== 1'b0)     begin errors++; $display("[TB] FAIL mid_ready: got %0b expected 0", o_ready); end
        if (o_init_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %0b expected 0", o_init_done); end
        test_powerup();
    endtask

    // Hard stop in case a DUT wait never resolves.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_reset = 1'b1;
        i_req   = 1'b0;
        i_rs    = 1'b0;
        i_data  = 8'h00;
        repeat (2) @(negedge i_clk);
        test_reset();
        test_powerup();
        test_data_write();
        test_long_command();
        test_random_writes();
        test_handshake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
